down_counter_sync_fft: RTL

Synchronous, loadable down-counter built from a chain of T flip-flops with a borrow chain, complementing the team's synchronous up-counter. Software or a controlling FSM loads a start value. The block decrements once per enabled clock until it reaches zero, then signals completion. It serves as the countdown/timeout timer in the Sincrono lab set, alongside the up-counter.

---
 rtl/down_counter_sync_fft.sv | 91 +++++++++
 1 files changed

// File: rtl/down_counter_sync_fft.sv
// Loadable synchronous down-counter: T flip-flops with a borrow chain and an IDLE/RUN FSM.
// Define DOWN_COUNTER_AUTORELOAD_EN to reload from the reload register at terminal count instead of stopping.
module down_counter_sync_fft #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             done_q;
    logic             done_d;

    logic             en_run;
    logic [WIDTH-1:0] t;
    logic             terminal;

    assign en_run   = en & (state_q == RUN);
    assign terminal = en_run & ~load & (count_q == WIDTH'(1));

    // Bit i toggles only when every lower bit is already zero (borrow ripples upward).
    always_comb begin
        logic chain;
        chain = en_run;
        t     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = chain;
            chain = chain & ~count_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q ^ t;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else if (terminal) begin
            done_d = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            count_d = reload_q;
            state_d = RUN;
`else
            count_d = '0;
            state_d = IDLE;
`endif
        end
    end

    always_comb begin
        count = count_q;
        zero  = (count_q == '0);
        busy  = (state_q == RUN);
        done  = done_q;
    end

endmodule
